exec_sequencer: RTL and testbench
=================================

Name: exec_sequencer

Overview:
- Multi-cycle control FSM that sequences one instruction at a time through decode, register-file read, ALU, LSU, PC-ALU and write-back.
- Sits between instruction fetch and the decode stage.
- Drives decode's req strobe and consumes decode's per-unit request flags.
- Handshakes with each execution resource, detects stuck units, counts retired instructions.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for any unit ack before timeout error (1..2^16-1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
instr_valid_i  in  1  fetch has instruction on instr bus
instr_ready_o  out  1  sequencer accepts instruction (high only in IDLE)
dec_req_o  out  1  one-cycle strobe to decode req_i
dec_req_rf_ra_i / dec_req_rf_rb_i  in  1  decode needs rs1 / rs2
dec_req_alu_i, dec_req_data_i, dec_we_data_i, dec_req_pc_alu_i  in  1  decode unit flags
dec_rf_waddr_i  in  5  decoded rd
rf_req_o  out  1  RF read request (level); rf_ack_i  in  1
alu_req_o  out  1  ALU request (level); alu_ack_i  in  1
lsu_req_o  out  1  LSU request (level); lsu_we_o  out  1  store flag
lsu_ack_i  in  1; lsu_err_i  in  1  bus error, valid with ack
pc_alu_req_o  out  1; pc_alu_ack_i  in  1; pc_redirect_i  in  1  taken jump/branch, valid with ack
rf_we_o  out  1  write-back strobe; rf_waddr_o  out  5
flush_o  out  1  one-cycle fetch flush on redirect
retire_o  out  1  one-cycle strobe per completed instruction
retire_cnt_o  out  CNT_W  retired count
err_o  out  1  sticky error; err_code_o  out  2  (pkg::seq_err_e)
err_clear_i  in  1  leave ERROR

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0 except instr_ready_o=1; counters 0. Request levels drop immediately.
- All outputs registered, decoded from state.
- IDLE: instr_ready_o=1. On instr_valid_i -> DEC1.
- DEC1: dec_req_o=1 for exactly this cycle -> DEC2.
- DEC2: samples decode flags into class register; rd latched.
  - All of alu/data/pc_alu flags 0 -> ERROR, code ILLEGAL.
  - Else, if ra|rb -> OPERANDS, else -> EXECUTE.
- OPERANDS: rf_req_o held until rf_ack_i -> EXECUTE.
- EXECUTE: alu_req_o held until alu_ack_i. Then data -> MEMORY; else pc_alu -> BRANCH; else -> WRITEBACK. If alu flag 0, EXECUTE is skipped with zero cycles (same decision).
- MEMORY: lsu_req_o=1, lsu_we_o=latched we. On lsu_ack_i:
  - lsu_err_i=1 -> ERROR, code BUS.
  - Else if pc_alu flag -> BRANCH, else -> WRITEBACK.
- BRANCH: pc_alu_req_o held until pc_alu_ack_i. If pc_redirect_i at ack, flush_o=1 the following cycle. Then -> WRITEBACK.
- WRITEBACK (1 cycle):
  - rf_we_o=1 iff not store, not (branch without alu ADD i.e. BRANCH class), and rd≠0.
  - retire_o=1; retire_cnt_o +1 (wraps 2^CNT_W-1 -> 0).
  - -> IDLE.
- Request/ack handshake:
  - A request rises on state entry and stays high until ack is sampled; it deasserts the cycle after.
  - Ack with no pending request is ignored.
- Timeout:
  - Wait counter clears on each state entry and increments while a request is pending.
  - On reaching TIMEOUT_CYCLES -> ERROR, code TIMEOUT.
  - Ack and timeout in the same cycle: ack wins.
- ERROR: err_o=1, err_code_o held, all requests 0, instr_ready_o=0. err_clear_i -> IDLE, err_o=0, code NONE. No new error captured while in ERROR.
- instr_valid_i outside IDLE is ignored.
- Minimum latency, OP_IMM with same-cycle acks: accept c0, DEC1 c1, DEC2 c2, OPERANDS c3, EXECUTE c4, WRITEBACK c5, ready again c6.

Decomposition:
- pkg gains seq_state_e (IDLE, DEC1, DEC2, OPERANDS, EXECUTE, MEMORY, BRANCH, WRITEBACK, ERROR).
- pkg gains seq_err_e (NONE=0, BUS=1, TIMEOUT=2, ILLEGAL=3).
- Sub-module wait_timer: clear/enable/expired counter parameterised by TIMEOUT_CYCLES.

Test Plan:
- ADDI (ra, alu), all acks same cycle -> dec_req_o at c1, rf_req_o c3, alu_req_o c4, rf_we_o=1 rf_waddr_o=5 at c5, retire_cnt_o=1.
- Store (ra, rb, alu, data, we), lsu_ack_i after 3 cycles -> lsu_we_o=1 held 3 cycles, rf_we_o=0, retire_o=1.
- BEQ taken: pc_alu_ack_i with pc_redirect_i=1 -> flush_o one cycle, rf_we_o=0. Not taken -> flush_o stays 0.
- TIMEOUT_CYCLES=4, alu_ack_i never -> err_o=1, err_code_o=2 after 4 wait cycles. err_clear_i -> IDLE, instr_ready_o=1.
- Load with lsu_err_i=1 at ack -> err_code_o=1. All-zero decode flags -> err_code_o=3.
- rst_i asserted mid-MEMORY -> lsu_req_o=0 without clock edge, retire_cnt_o=0. CNT_W=4 with 16 retires -> count wraps to 0.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared types and helpers for the multi-cycle instruction execution sequencer.
package exec_sequencer_pkg;

  localparam int WAIT_W = 16;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEC1      = 4'd1,
    DEC2      = 4'd2,
    OPERANDS  = 4'd3,
    EXECUTE   = 4'd4,
    MEMORY    = 4'd5,
    BRANCH    = 4'd6,
    WRITEBACK = 4'd7,
    ERROR     = 4'd8
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BUS     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ILLEGAL = 2'd3
  } seq_err_e;

  // Unit usage of the instruction in flight; operand flags are only needed in DEC2.
  typedef struct packed {
    logic alu;
    logic data;
    logic we;
    logic pc_alu;
  } dec_class_t;

  // Next stop once the ALU phase is finished or skipped.
  function automatic seq_state_e after_execute(input dec_class_t cls);
    if (cls.data) begin
      return MEMORY;
    end else if (cls.pc_alu) begin
      return BRANCH;
    end else begin
      return WRITEBACK;
    end
  endfunction

  // Stores and pure branches (PC-ALU without an ALU link add) never write rd; x0 is never written.
  function automatic logic writes_rd(input dec_class_t cls, input logic [4:0] rd);
    return !(cls.data && cls.we) && !(cls.pc_alu && !cls.alu) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/exec_sequencer_wait_timer.sv
// Per-state wait counter: cleared on state entry, counts while a request is pending.
module exec_sequencer_wait_timer
  import exec_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] count_q;

  // expired flags the TIMEOUT_CYCLES-th waiting cycle; the counter saturates there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_q <= count_q + WAIT_W'(1);
    end
  end

  assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/exec_sequencer.sv
// Sequences one instruction at a time through decode, RF read, ALU, LSU, PC-ALU and write-back.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  output logic             dec_req_o,
  input  logic             dec_req_rf_ra_i,
  input  logic             dec_req_rf_rb_i,
  input  logic             dec_req_alu_i,
  input  logic             dec_req_data_i,
  input  logic             dec_we_data_i,
  input  logic             dec_req_pc_alu_i,
  input  logic [4:0]       dec_rf_waddr_i,
  output logic             rf_req_o,
  input  logic             rf_ack_i,
  output logic             alu_req_o,
  input  logic             alu_ack_i,
  output logic             lsu_req_o,
  output logic             lsu_we_o,
  input  logic             lsu_ack_i,
  input  logic             lsu_err_i,
  output logic             pc_alu_req_o,
  input  logic             pc_alu_ack_i,
  input  logic             pc_redirect_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic             flush_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  input  logic             err_clear_i,
  output logic [3:0]       dbg_state_o
);

  // Handshake: a unit request is a level that rises on entry to its state and
  // holds until the matching ack is sampled on a clock edge; it drops the cycle
  // after. Acks arriving while no request is pending are ignored, and an ack in
  // the same cycle as the timeout takes priority over the timeout.

  seq_state_e       state_q, state_n;
  dec_class_t       cls_q, cls_n;
  logic [4:0]       rd_q, rd_n;
  seq_err_e         err_code_q, err_code_n;
  logic [CNT_W-1:0] cnt_n;

  logic             pending;
  logic             expired;

  logic             instr_ready_n, dec_req_n, rf_req_n, alu_req_n;
  logic             lsu_req_n, lsu_we_n, pc_alu_req_n;
  logic             rf_we_n, flush_n, retire_n, err_n;
  logic [4:0]       rf_waddr_n;

  assign pending = (state_q == OPERANDS) || (state_q == EXECUTE) ||
                   (state_q == MEMORY)   || (state_q == BRANCH);

  exec_sequencer_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (state_n != state_q),
    .enable  (pending),
    .expired (expired)
  );

  always_comb begin
    state_n    = state_q;
    cls_n      = cls_q;
    rd_n       = rd_q;
    err_code_n = err_code_q;

    case (state_q)
      IDLE: begin
        if (instr_valid_i) state_n = DEC1;
      end
      DEC1: begin
        state_n = DEC2;
      end
      DEC2: begin
        cls_n.alu    = dec_req_alu_i;
        cls_n.data   = dec_req_data_i;
        cls_n.we     = dec_we_data_i;
        cls_n.pc_alu = dec_req_pc_alu_i;
        rd_n         = dec_rf_waddr_i;
        if (!(dec_req_alu_i || dec_req_data_i || dec_req_pc_alu_i)) begin
          state_n    = ERROR;
          err_code_n = ERR_ILLEGAL;
        end else if (dec_req_rf_ra_i || dec_req_rf_rb_i) begin
          state_n = OPERANDS;
        end else begin
          state_n = cls_n.alu ? EXECUTE : after_execute(cls_n);
        end
      end
      OPERANDS: begin
        if (rf_ack_i) begin
          state_n = cls_q.alu ? EXECUTE : after_execute(cls_q);
        end else if (expired) begin
          state_n    = ERROR;
          err_code_n = ERR_TIMEOUT;
        end
      end
      EXECUTE: begin
        if (alu_ack_i) begin
          state_n = after_execute(cls_q);
        end else if (expired) begin
          state_n    = ERROR;
          err_code_n = ERR_TIMEOUT;
        end
      end
      MEMORY: begin
        if (lsu_ack_i) begin
          if (lsu_err_i) begin
            state_n    = ERROR;
            err_code_n = ERR_BUS;
          end else begin
            state_n = cls_q.pc_alu ? BRANCH : WRITEBACK;
          end
        end else if (expired) begin
          state_n    = ERROR;
          err_code_n = ERR_TIMEOUT;
        end
      end
      BRANCH: begin
        if (pc_alu_ack_i) begin
          state_n = WRITEBACK;
        end else if (expired) begin
          state_n    = ERROR;
          err_code_n = ERR_TIMEOUT;
        end
      end
      WRITEBACK: begin
        state_n = IDLE;
      end
      ERROR: begin
        if (err_clear_i) begin
          state_n    = IDLE;
          err_code_n = ERR_NONE;
        end
      end
      default: begin
        state_n    = IDLE;
        err_code_n = ERR_NONE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    instr_ready_n = (state_n == IDLE);
    dec_req_n     = (state_n == DEC1);
    rf_req_n      = (state_n == OPERANDS);
    alu_req_n     = (state_n == EXECUTE);
    lsu_req_n     = (state_n == MEMORY);
    lsu_we_n      = (state_n == MEMORY) && cls_n.we;
    pc_alu_req_n  = (state_n == BRANCH);
    retire_n      = (state_n == WRITEBACK);
    rf_we_n       = retire_n && writes_rd(cls_n, rd_n);
    rf_waddr_n    = retire_n ? rd_n : 5'd0;
    flush_n       = (state_q == BRANCH) && pc_alu_ack_i && pc_redirect_i;
    err_n         = (state_n == ERROR);
    cnt_n         = retire_n ? (retire_cnt_o + CNT_W'(1)) : retire_cnt_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cls_q         <= '0;
      rd_q          <= '0;
      err_code_q    <= ERR_NONE;
      instr_ready_o <= 1'b1;
      dec_req_o     <= 1'b0;
      rf_req_o      <= 1'b0;
      alu_req_o     <= 1'b0;
      lsu_req_o     <= 1'b0;
      lsu_we_o      <= 1'b0;
      pc_alu_req_o  <= 1'b0;
      rf_we_o       <= 1'b0;
      rf_waddr_o    <= '0;
      flush_o       <= 1'b0;
      retire_o      <= 1'b0;
      retire_cnt_o  <= '0;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_n;
      cls_q         <= cls_n;
      rd_q          <= rd_n;
      err_code_q    <= err_code_n;
      instr_ready_o <= instr_ready_n;
      dec_req_o     <= dec_req_n;
      rf_req_o      <= rf_req_n;
      alu_req_o     <= alu_req_n;
      lsu_req_o     <= lsu_req_n;
      lsu_we_o      <= lsu_we_n;
      pc_alu_req_o  <= pc_alu_req_n;
      rf_we_o       <= rf_we_n;
      rf_waddr_o    <= rf_waddr_n;
      flush_o       <= flush_n;
      retire_o      <= retire_n;
      retire_cnt_o  <= cnt_n;
      err_o         <= err_n;
    end
  end

  assign err_code_o  = err_code_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a short timeout and a 4-bit retire counter.
module tb_exec_sequencer;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid_i;
  logic          instr_ready_o;
  logic          dec_req_o;
  logic          dec_req_rf_ra_i, dec_req_rf_rb_i, dec_req_alu_i;
  logic          dec_req_data_i, dec_we_data_i, dec_req_pc_alu_i;
  logic [4:0]    dec_rf_waddr_i;
  logic          rf_req_o, rf_ack_i, alu_req_o, alu_ack_i;
  logic          lsu_req_o, lsu_we_o, lsu_ack_i, lsu_err_i;
  logic          pc_alu_req_o, pc_alu_ack_i, pc_redirect_i;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic          flush_o, retire_o;
  logic [CW-1:0] retire_cnt_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic          err_clear_i;
  logic [3:0]    dbg_state_o;

  int checks = 0;
  int errors = 0;

  exec_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .instr_valid_i    (instr_valid_i),
    .instr_ready_o    (instr_ready_o),
    .dec_req_o        (dec_req_o),
    .dec_req_rf_ra_i  (dec_req_rf_ra_i),
    .dec_req_rf_rb_i  (dec_req_rf_rb_i),
    .dec_req_alu_i    (dec_req_alu_i),
    .dec_req_data_i   (dec_req_data_i),
    .dec_we_data_i    (dec_we_data_i),
    .dec_req_pc_alu_i (dec_req_pc_alu_i),
    .dec_rf_waddr_i   (dec_rf_waddr_i),
    .rf_req_o         (rf_req_o),
    .rf_ack_i         (rf_ack_i),
    .alu_req_o        (alu_req_o),
    .alu_ack_i        (alu_ack_i),
    .lsu_req_o        (lsu_req_o),
    .lsu_we_o         (lsu_we_o),
    .lsu_ack_i        (lsu_ack_i),
    .lsu_err_i        (lsu_err_i),
    .pc_alu_req_o     (pc_alu_req_o),
    .pc_alu_ack_i     (pc_alu_ack_i),
    .pc_redirect_i    (pc_redirect_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .flush_o          (flush_o),
    .retire_o         (retire_o),
    .retire_cnt_o     (retire_cnt_o),
    .err_o            (err_o),
    .err_code_o       (err_code_o),
    .err_clear_i      (err_clear_i),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic ra, input logic rb, input logic alu, input logic data,
                         input logic we, input logic pc, input logic [4:0] rd);
    dec_req_rf_ra_i  = ra;
    dec_req_rf_rb_i  = rb;
    dec_req_alu_i    = alu;
    dec_req_data_i   = data;
    dec_we_data_i    = we;
    dec_req_pc_alu_i = pc;
    dec_rf_waddr_i   = rd;
  endtask

  task automatic set_acks(input logic rf, input logic alu, input logic lsu, input logic pc);
    rf_ack_i     = rf;
    alu_ack_i    = alu;
    lsu_ack_i    = lsu;
    pc_alu_ack_i = pc;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the DEC2 cycle.
  task automatic start_instr();
    check("ready_idle", instr_ready_o, 1);
    instr_valid_i = 1'b1;
    cyc();
    check("dec_req_c1", dec_req_o, 1);
    check("ready_busy", instr_ready_o, 0);
    instr_valid_i = 1'b0;
    cyc();
    check("dec_req_c2", dec_req_o, 0);
  endtask

  task automatic clear_error();
    err_clear_i = 1'b1;
    cyc();
    err_clear_i = 1'b0;
    check("clr_err", err_o, 0);
    check("clr_code", err_code_o, 0);
    check("clr_ready", instr_ready_o, 1);
  endtask

  // Directed sequence; expected values are hand-derived from the cycle plan of each case.
  initial begin
    rst = 1'b1;
    instr_valid_i = 1'b0;
    err_clear_i = 1'b0;
    lsu_err_i = 1'b0;
    pc_redirect_i = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 5'd0);
    set_acks(0, 0, 0, 0);
    cyc();
    cyc();
    check("rst_ready", instr_ready_o, 1);
    check("rst_dec_req", dec_req_o, 0);
    check("rst_cnt", retire_cnt_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", dbg_state_o, 0);
    rst = 1'b0;

    // ADDI x5: ra + alu, all acks in the same cycle
    set_dec(1, 0, 1, 0, 0, 0, 5'd5);
    set_acks(1, 1, 0, 0);
    start_instr();
    cyc();
    check("addi_rf_req_c3", rf_req_o, 1);
    cyc();
    check("addi_alu_req_c4", alu_req_o, 1);
    check("addi_rf_req_c4", rf_req_o, 0);
    cyc();
    check("addi_we_c5", rf_we_o, 1);
    check("addi_waddr_c5", rf_waddr_o, 5);
    check("addi_retire_c5", retire_o, 1);
    check("addi_cnt_c5", retire_cnt_o, 1);
    check("addi_alu_req_c5", alu_req_o, 0);
    cyc();
    check("addi_ready_c6", instr_ready_o, 1);
    check("addi_retire_c6", retire_o, 0);
    check("addi_we_c6", rf_we_o, 0);

    // Store with rd field nonzero; LSU acks on the third MEMORY cycle
    set_dec(1, 1, 1, 1, 1, 0, 5'd7);
    set_acks(1, 1, 0, 0);
    start_instr();
    cyc();
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("st_lsu_req", lsu_req_o, 1);
      check("st_lsu_we", lsu_we_o, 1);
      if (i == 2) lsu_ack_i = 1'b1;
      cyc();
    end
    lsu_ack_i = 1'b0;
    check("st_lsu_req_drop", lsu_req_o, 0);
    check("st_lsu_we_drop", lsu_we_o, 0);
    check("st_rf_we", rf_we_o, 0);
    check("st_retire", retire_o, 1);
    check("st_cnt", retire_cnt_o, 2);
    cyc();

    // BEQ taken: no ALU, so EXECUTE is skipped straight into BRANCH
    set_dec(1, 1, 0, 0, 0, 1, 5'd3);
    set_acks(1, 1, 0, 1);
    pc_redirect_i = 1'b1;
    start_instr();
    cyc();
    cyc();
    check("beq_pc_req", pc_alu_req_o, 1);
    check("beq_alu_skip", alu_req_o, 0);
    check("beq_state", dbg_state_o, 6);
    cyc();
    check("beq_flush", flush_o, 1);
    check("beq_rf_we", rf_we_o, 0);
    check("beq_cnt", retire_cnt_o, 3);
    cyc();
    check("beq_flush_drop", flush_o, 0);

    // BEQ not taken
    pc_redirect_i = 1'b0;
    start_instr();
    cyc();
    cyc();
    cyc();
    check("bnt_flush", flush_o, 0);
    check("bnt_retire", retire_o, 1);
    check("bnt_cnt", retire_cnt_o, 4);
    cyc();

    // JAL x1: ALU link add plus PC-ALU, no operands
    set_dec(0, 0, 1, 0, 0, 1, 5'd1);
    pc_redirect_i = 1'b1;
    start_instr();
    cyc();
    check("jal_alu_req", alu_req_o, 1);
    check("jal_rf_req", rf_req_o, 0);
    cyc();
    check("jal_pc_req", pc_alu_req_o, 1);
    cyc();
    check("jal_flush", flush_o, 1);
    check("jal_rf_we", rf_we_o, 1);
    check("jal_waddr", rf_waddr_o, 1);
    check("jal_cnt", retire_cnt_o, 5);
    pc_redirect_i = 1'b0;
    cyc();

    // ALU never acks: four wait cycles then TIMEOUT
    set_dec(1, 0, 1, 0, 0, 0, 5'd2);
    set_acks(1, 0, 0, 0);
    start_instr();
    cyc();
    cyc();
    for (int i = 0; i < TO; i++) begin
      check("to_alu_req", alu_req_o, 1);
      check("to_err_wait", err_o, 0);
      cyc();
    end
    check("to_err", err_o, 1);
    check("to_code", err_code_o, 2);
    check("to_alu_drop", alu_req_o, 0);
    check("to_ready", instr_ready_o, 0);
    check("to_state", dbg_state_o, 8);
    instr_valid_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0;
    check("to_sticky", err_o, 1);
    check("to_ignore_valid", dec_req_o, 0);
    clear_error();

    // Load with bus error on the fourth MEMORY cycle: ack beats timeout
    set_dec(1, 0, 1, 1, 0, 0, 5'd4);
    set_acks(1, 1, 0, 0);
    start_instr();
    cyc();
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("ld_lsu_req", lsu_req_o, 1);
      check("ld_lsu_we", lsu_we_o, 0);
      cyc();
    end
    check("ld_lsu_req_m4", lsu_req_o, 1);
    lsu_ack_i = 1'b1;
    lsu_err_i = 1'b1;
    cyc();
    lsu_ack_i = 1'b0;
    lsu_err_i = 1'b0;
    check("bus_err", err_o, 1);
    check("bus_code", err_code_o, 1);
    check("bus_lsu_drop", lsu_req_o, 0);
    check("bus_cnt", retire_cnt_o, 5);
    clear_error();

    // All unit flags zero -> ILLEGAL
    set_dec(1, 0, 0, 0, 0, 0, 5'd9);
    start_instr();
    cyc();
    check("ill_err", err_o, 1);
    check("ill_code", err_code_o, 3);
    check("ill_rf_req", rf_req_o, 0);
    clear_error();

    // Asynchronous reset in the middle of MEMORY
    set_dec(1, 0, 1, 1, 0, 0, 5'd4);
    start_instr();
    cyc();
    cyc();
    cyc();
    check("ar_lsu_req", lsu_req_o, 1);
    check("ar_cnt_before", retire_cnt_o, 5);
    #2;
    rst = 1'b1;
    #1;
    check("ar_lsu_drop", lsu_req_o, 0);
    check("ar_cnt", retire_cnt_o, 0);
    check("ar_ready", instr_ready_o, 1);
    cyc();
    rst = 1'b0;

    // Sixteen ALU-only retires wrap the 4-bit counter back to zero
    set_dec(0, 0, 1, 0, 0, 0, 5'd6);
    set_acks(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      logic [CW-1:0] exp_cnt;
      exp_cnt = CW'(i + 1);
      start_instr();
      cyc();
      cyc();
      check("wrap_retire", retire_o, 1);
      check("wrap_cnt", retire_cnt_o, exp_cnt);
      cyc();
    end
    check("wrap_zero", retire_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
